conn90_pin_tx: RTL and testbench

Pin-side transmitter for the 90-pin board-to-board connector. It accepts parallel words from local logic and sends them across the connector in BUS_W-bit beats, using a four-phase strobe/acknowledge handshake toward the jack-side card. It also owns the output-enable of the shared data pins, synchronises the incoming acknowledge, and aborts with an error pulse if the far end stops responding.

---
 rtl/conn90_pkg.sv | 23 ++
 rtl/conn90_sync2.sv | 19 +
 rtl/conn90_pin_tx.sv | 116 +++++++++++
 tb/tb_conn90_pin_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conn90_pkg.sv
// conn90_pkg: shared states and helpers for the 90-pin connector transmitter and receiver
package conn90_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT_HI,
        WAIT_LO
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int beats(input int data_w, input int bus_w);
        return data_w / bus_w;
    endfunction

endpackage

// File: rtl/conn90_sync2.sv
// conn90_sync2: two-flop synchroniser for a single asynchronous control line
module conn90_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] s_q;

    // shift the async input through two flops before anything looks at it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) s_q <= '0;
        else s_q <= {s_q[0], d_i};
    end

    assign q_o = s_q[1];

endmodule

// File: rtl/conn90_pin_tx.sv
// conn90_pin_tx: splits local words into connector beats sent with a four-phase strobe/ack handshake
module conn90_pin_tx
    import conn90_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int BUS_W       = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic [BUS_W-1:0]  BUS_D,
    output logic              BUS_OE,
    output logic              BUS_STB,
    output logic              BUS_LAST,
    input  logic              BUS_ACK,
    output logic              BUSY,
    output logic              ERR_TIMEOUT
);

    localparam int BEATS  = beats(DATA_W, BUS_W);
    localparam int BEAT_W = BEATS > 1 ? clog2(BEATS) : 1;
    localparam int CNT_W  = clog2(ACK_TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(ACK_TIMEOUT);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                ack_s;
    logic                in_wait;
    logic                timeout;

    conn90_sync2 u_ack_sync (
        .clk_i (CLK),
        .rst_ni(RST_N),
        .d_i   (BUS_ACK),
        .q_o   (ack_s)
    );

    assign in_wait = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    assign timeout = in_wait && (cnt_q == CNT_MAX);

    // handshake sequencing; a timeout wins over a same-cycle ack so an abort is never half-taken
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        beat_d  = beat_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (TX_VALID) begin
                    sr_d    = TX_DATA;
                    beat_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: state_d = WAIT_HI;
            WAIT_HI: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (ack_s) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!ack_s) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end else begin
                        sr_d    = sr_q >> BUS_W;
                        beat_d  = beat_q + 1'b1;
                        state_d = SETUP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (in_wait && state_d == state_q) ? cnt_q + 1'b1 : '0;
    end

    // state, data and counters; async reset so the pins release the moment reset lands
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sr_q    <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign TX_READY    = state_q == IDLE;
    assign BUSY        = state_q != IDLE;
    assign BUS_OE      = state_q != IDLE;
    assign BUS_STB     = (state_q == STROBE) || (state_q == WAIT_HI);
    assign BUS_D       = BUS_OE ? sr_q[BUS_W-1:0] : '0;
    assign BUS_LAST    = BUS_OE && (beat_q == LAST_BEAT);
    assign ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_conn90_pin_tx.sv
// tb_conn90_pin_tx: directed checks of the connector transmitter against a far-end ack model
module tb_conn90_pin_tx;

    logic        CLK;
    logic        RST_N;
    logic [31:0] TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic [15:0] BUS_D;
    logic        BUS_OE;
    logic        BUS_STB;
    logic        BUS_LAST;
    logic        BUS_ACK;
    logic        BUSY;
    logic        ERR_TIMEOUT;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int beats_seen = 0;
    int ack_mode = 0;
    int dly = 0;
    logic [16:0] exp_q[$];
    logic        prev_stb = 1'b0;
    logic [16:0] prev_beat = '0;

    conn90_pin_tx #(
        .DATA_W     (32),
        .BUS_W      (16),
        .ACK_TIMEOUT(10)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .BUS_D      (BUS_D),
        .BUS_OE     (BUS_OE),
        .BUS_STB    (BUS_STB),
        .BUS_LAST   (BUS_LAST),
        .BUS_ACK    (BUS_ACK),
        .BUSY       (BUSY),
        .ERR_TIMEOUT(ERR_TIMEOUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // far end: 0 silent, 1 echo strobe, 2 stick high once strobed, 3 echo with jitter, 4 echo except on last beat
    initial begin
        BUS_ACK = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            case (ack_mode)
                1: BUS_ACK = BUS_STB;
                2: if (BUS_STB) BUS_ACK = 1'b1;
                3: if (BUS_STB !== BUS_ACK) begin
                    if (dly == 0) begin
                        #($urandom_range(0, 5));
                        BUS_ACK = BUS_STB;
                        dly = $urandom_range(0, 5);
                    end else begin
                        dly--;
                    end
                end
                4: BUS_ACK = BUS_STB && !BUS_LAST;
                default: ;
            endcase
        end
    end

    // scoreboard: every strobe rise must match the next expected beat, and data must hold while strobed
    initial begin
        forever begin
            @(negedge CLK);
            if (ERR_TIMEOUT) err_pulses++;
            if (BUS_STB && !prev_stb) begin
                beats_seen++;
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("beat_data", {15'd0, BUS_LAST, BUS_D}, {15'd0, exp_q.pop_front()});
            end
            if (BUS_STB && prev_stb) chk("stb_stable", {15'd0, BUS_LAST, BUS_D}, {15'd0, prev_beat});
            prev_stb  = BUS_STB;
            prev_beat = {BUS_LAST, BUS_D};
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_mode(input int m);
        ack_mode = m;
        dly = 0;
        BUS_ACK = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input int nb);
        for (int k = 0; k < nb; k++) exp_q.push_back({k == 1, w[16*k +: 16]});
    endtask

    task automatic send(input logic [31:0] w, input bit hold);
        int n = 0;
        TX_DATA  = w;
        TX_VALID = 1'b1;
        while (!TX_READY && n < 500) begin
            cyc(1);
            n++;
        end
        chk("ready_wait", 32'(n < 500), 32'd1);
        cyc(1);
        if (!hold) TX_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 500) begin
            cyc(1);
            n++;
        end
        chk("idle_wait", 32'(n < 500), 32'd1);
    endtask

    task automatic wait_err(output int n);
        n = 0;
        while (!ERR_TIMEOUT && n < 60) begin
            cyc(1);
            n++;
        end
    endtask

    initial begin
        int n;
        int e0;
        int b0;
        logic [31:0] w;
        RST_N    = 1'b0;
        TX_VALID = 1'b0;
        TX_DATA  = '0;
        cyc(2);
        chk("rst_ready", 32'(TX_READY), 32'd1);
        chk("rst_oe", 32'(BUS_OE), 32'd0);
        chk("rst_stb", 32'(BUS_STB), 32'd0);
        chk("rst_d", 32'(BUS_D), 32'd0);
        chk("rst_last", 32'(BUS_LAST), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_err", 32'(ERR_TIMEOUT), 32'd0);
        RST_N = 1'b1;
        cyc(2);

        set_mode(1);
        push_word(32'hDEADBEEF, 2);
        send(32'hDEADBEEF, 1'b0);
        chk("t1_ready_low", 32'(TX_READY), 32'd0);
        chk("t1_oe", 32'(BUS_OE), 32'd1);
        chk("t1_d0", 32'(BUS_D), 32'h0000BEEF);
        chk("t1_last0", 32'(BUS_LAST), 32'd0);
        chk("t1_stb_setup", 32'(BUS_STB), 32'd0);
        cyc(1);
        chk("t1_stb_rise", 32'(BUS_STB), 32'd1);
        wait_idle();
        chk("t1_oe_off", 32'(BUS_OE), 32'd0);
        chk("t1_ack_low", 32'(BUS_ACK), 32'd0);
        chk("t1_drain", 32'(exp_q.size()), 32'd0);
        chk("t1_no_err", 32'(err_pulses), 32'd0);

        b0 = beats_seen;
        push_word(32'h00000001, 2);
        push_word(32'hFFFFFFFF, 2);
        send(32'h00000001, 1'b1);
        chk("t2_d0", 32'(BUS_D), 32'h00000001);
        TX_DATA = 32'hFFFFFFFF;
        n = 0;
        while (!TX_READY && n < 200) begin
            cyc(1);
            n++;
        end
        chk("t2_gap_seen", 32'(n < 200), 32'd1);
        chk("t2_gap_oe", 32'(BUS_OE), 32'd0);
        chk("t2_gap_busy", 32'(BUSY), 32'd0);
        cyc(1);
        TX_VALID = 1'b0;
        chk("t2_second_d0", 32'(BUS_D), 32'h0000FFFF);
        chk("t2_second_busy", 32'(BUSY), 32'd1);
        wait_idle();
        chk("t2_drain", 32'(exp_q.size()), 32'd0);
        chk("t2_beats", 32'(beats_seen - b0), 32'd4);

        set_mode(0);
        e0 = err_pulses;
        push_word(32'hA5A55A5A, 1);
        send(32'hA5A55A5A, 1'b0);
        wait_err(n);
        chk("t3_err_delay", 32'(n), 32'd13);
        chk("t3_stb", 32'(BUS_STB), 32'd0);
        chk("t3_oe", 32'(BUS_OE), 32'd0);
        chk("t3_ready", 32'(TX_READY), 32'd1);
        cyc(1);
        chk("t3_err_one", 32'(ERR_TIMEOUT), 32'd0);
        chk("t3_err_count", 32'(err_pulses - e0), 32'd1);
        chk("t3_drain", 32'(exp_q.size()), 32'd0);

        set_mode(2);
        e0 = err_pulses;
        b0 = beats_seen;
        push_word(32'h13579BDF, 1);
        send(32'h13579BDF, 1'b0);
        wait_err(n);
        chk("t4_err_delay", 32'(n), 32'd15);
        chk("t4_oe", 32'(BUS_OE), 32'd0);
        chk("t4_stb", 32'(BUS_STB), 32'd0);
        cyc(3);
        chk("t4_err_count", 32'(err_pulses - e0), 32'd1);
        chk("t4_beats", 32'(beats_seen - b0), 32'd1);
        chk("t4_drain", 32'(exp_q.size()), 32'd0);
        set_mode(0);
        cyc(4);

        set_mode(4);
        e0 = err_pulses;
        push_word(32'h0BADF00D, 2);
        send(32'h0BADF00D, 1'b0);
        n = 0;
        while (!(BUS_STB && BUS_LAST) && n < 100) begin
            cyc(1);
            n++;
        end
        chk("t5_beat1_seen", 32'(n < 100), 32'd1);
        cyc(3);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t5_rst_oe", 32'(BUS_OE), 32'd0);
        chk("t5_rst_stb", 32'(BUS_STB), 32'd0);
        chk("t5_rst_busy", 32'(BUSY), 32'd0);
        chk("t5_rst_ready", 32'(TX_READY), 32'd1);
        chk("t5_rst_last", 32'(BUS_LAST), 32'd0);
        @(posedge CLK);
        #3;
        RST_N = 1'b1;
        cyc(1);
        chk("t5_no_err", 32'(err_pulses - e0), 32'd0);
        chk("t5_drain", 32'(exp_q.size()), 32'd0);
        set_mode(1);
        push_word(32'h12345678, 2);
        send(32'h12345678, 1'b0);
        chk("t5_restart_d", 32'(BUS_D), 32'h00005678);
        chk("t5_restart_last", 32'(BUS_LAST), 32'd0);
        wait_idle();
        chk("t5_restart_drain", 32'(exp_q.size()), 32'd0);

        set_mode(3);
        e0 = err_pulses;
        b0 = beats_seen;
        for (int i = 0; i < 1000; i++) begin
            w = $urandom;
            push_word(w, 2);
            send(w, 1'b0);
        end
        wait_idle();
        chk("t6_drain", 32'(exp_q.size()), 32'd0);
        chk("t6_no_err", 32'(err_pulses - e0), 32'd0);
        chk("t6_beats", 32'(beats_seen - b0), 32'd2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
